vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing and RGB565 test-pattern generator.
//   A horizontal/vertical counter pair walks the full raster; every output is
//   registered from that counter state, so all outputs are mutually aligned.
//   Pattern controls are latched once per frame at pixel (0,0) so a frame is
//   never torn by a mid-frame change.
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   mode         pattern select: 0 bars, 1 checker, 2 grid, 3 solid
//   solid_rgb    RGB565 colour used by mode 3
//   scroll_en    advance the horizontal scroll offset once per frame
//   hsync/vsync  sync pulses, active level set by HS_POL/VS_POL
//   de           active-video flag
//   x, y         pixel coordinates while de=1, otherwise 0
//   frame_start  one-cycle pulse when pixel (0,0) is presented
//   frame_cnt    completed-frame counter (wraps at 2^16)
//   red/green/blue  5/6/5 colour, 0 outside active video
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CHECK_LOG2 = 5,
  parameter int GRID_LOG2  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 solid_rgb,
  input  logic                        scroll_en,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic                        frame_start,
  output logic [15:0]                 frame_cnt,
  output logic [4:0]                  red,
  output logic [5:0]                  green,
  output logic [4:0]                  blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    mode_sh;
  logic [15:0]   rgb_sh;
  logic          scroll_sh;
  logic [XW-1:0] off;

  logic          at_origin, h_last, v_last;
  logic [1:0]    mode_eff;
  logic [15:0]   rgb_eff;
  logic          scroll_eff;
  logic [XW-1:0] off_eff;
  logic          de_c, hs_act, vs_act;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;
  logic [XW:0]   xs_sum, xs;
  logic [7:1]    bar_ge;
  logic [2:0]    bar;
  logic          chk_odd, grid_on;
  logic [15:0]   colour;

  // At (0,0) the frame being started must already use the freshly sampled
  // controls, so the shadow values are bypassed in that one cycle.  The
  // scroll step uses the previous frame's latched enable, which keeps the
  // offset constant across the whole frame including its first pixel.
  always_comb begin
    at_origin  = (h_cnt == '0) && (v_cnt == '0);
    h_last     = int'(h_cnt) == H_TOTAL - 1;
    v_last     = int'(v_cnt) == V_TOTAL - 1;
    mode_eff   = at_origin ? mode      : mode_sh;
    rgb_eff    = at_origin ? solid_rgb : rgb_sh;
    scroll_eff = at_origin ? scroll_en : scroll_sh;
    off_eff    = off;
    if (at_origin && scroll_sh)
      off_eff = (int'(off) == H_ACTIVE - 1) ? '0 : off + 1'b1;
  end

  always_comb begin
    de_c   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    x_c    = de_c ? XW'(h_cnt) : '0;
    y_c    = de_c ? YW'(v_cnt) : '0;
    hs_act = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    vs_act = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    // x and off are both below H_ACTIVE, so one conditional subtract is a full modulo
    xs_sum = {1'b0, x_c} + {1'b0, off_eff};
    xs     = (int'(xs_sum) >= H_ACTIVE) ? xs_sum - (XW+1)'(H_ACTIVE) : xs_sum;
  end

  // Bar index floor(xs*8/H_ACTIVE) without a divider: count how many of the
  // seven bar boundaries xs*8 has reached.
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_ge[gi] = int'({xs, 3'b000}) >= gi * H_ACTIVE;
  end

  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++)
      bar = bar + 3'(bar_ge[i]);
    chk_odd = (((int'(xs) >> CHECK_LOG2) ^ (int'(y_c) >> CHECK_LOG2)) & 1) != 0;
    grid_on = ((int'(xs) & ((1 << GRID_LOG2) - 1)) == 0) ||
              ((int'(y_c) & ((1 << GRID_LOG2) - 1)) == 0) ||
              (int'(x_c) == H_ACTIVE - 1) || (int'(y_c) == V_ACTIVE - 1);
    // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
    // R=~bar[1], G=~bar[2], B=~bar[0].
    case (mode_eff)
      2'd0:    colour = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
      2'd1:    colour = chk_odd ? 16'h0000 : 16'hFFFF;
      2'd2:    colour = grid_on ? 16'hFFFF : 16'h0000;
      default: colour = rgb_eff;
    endcase
    if (!de_c)
      colour = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_sh     <= 2'd0;
      rgb_sh      <= '0;
      scroll_sh   <= 1'b0;
      off         <= '0;
      frame_cnt   <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      if (h_last && v_last)
        frame_cnt <= frame_cnt + 16'd1;
      mode_sh     <= mode_eff;
      rgb_sh      <= rgb_eff;
      scroll_sh   <= scroll_eff;
      off         <= off_eff;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= de_c;
      x           <= x_c;
      y           <= y_c;
      frame_start <= at_origin;
      red         <= colour[15:11];
      green       <= colour[10:5];
      blue        <= colour[4:0];
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a small 16x4 raster
// (H_TOTAL=22, V_TOTAL=8, 176 clocks per frame).  The stimulus process
// pushes the reference model's expected outputs for every clock; the monitor
// pops and compares one entry per clock after the edge.
module tb_vga_pattern_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 1;
  localparam int VA = 4,  VFP = 1, VSW = 2, VBP = 1;
  localparam bit HSP = 1'b1, VSP = 1'b0;
  localparam int CL = 2, GL = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        scroll_en = 1'b0;
  logic        hsync, vsync, de, frame_start;
  logic [3:0]  x;
  logic [1:0]  y;
  logic [15:0] frame_cnt;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CHECK_LOG2(CL), .GRID_LOG2(GL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .scroll_en(scroll_en), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .red(red), .green(green), .blue(blue)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [3:0]  x;
    logic [1:0]  y;
    logic        fs;
    logic [15:0] fc;
    logic [15:0] rgb;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state: clocks since reset release, scroll offset, latched controls
  int   m_n = 0;
  int   m_off = 0;
  int   sh_mode = 0;
  int   sh_rgb = 0;
  int   sh_scroll = 0;

  // bar colours, left to right
  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic model_step(input logic r, output obs_t e);
    int h, v, xs;
    e = '0;
    if (!r) begin
      e.hs = ~HSP;
      e.vs = ~VSP;
      m_n = 0; m_off = 0; sh_mode = 0; sh_rgb = 0; sh_scroll = 0;
    end else begin
      h = m_n % HT;
      v = (m_n / HT) % VT;
      if (h == 0 && v == 0) begin
        m_off     = (m_off + sh_scroll) % HA;
        sh_mode   = int'(mode);
        sh_rgb    = int'(solid_rgb);
        sh_scroll = int'(scroll_en);
      end
      e.de = (h < HA) && (v < VA);
      e.x  = e.de ? 4'(h) : 4'd0;
      e.y  = e.de ? 2'(v) : 2'd0;
      e.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : ~HSP;
      e.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VSP : ~VSP;
      e.fs = (h == 0) && (v == 0);
      e.fc = 16'(((m_n + 1) / FT) % 65536);
      if (e.de) begin
        xs = (h + m_off) % HA;
        case (sh_mode)
          0: e.rgb = bar_tab[xs * 8 / HA];
          1: e.rgb = ((((xs >> CL) ^ (v >> CL)) & 1) == 0) ? 16'hFFFF : 16'h0000;
          2: e.rgb = ((xs % (1 << GL)) == 0 || (v % (1 << GL)) == 0 ||
                      h == HA - 1 || v == VA - 1) ? 16'hFFFF : 16'h0000;
          default: e.rgb = 16'(sh_rgb);
        endcase
      end
      m_n++;
    end
  endtask

  // one clock: inputs are already set; record expectation, pass the edge
  task automatic cyc(input logic r);
    obs_t e;
    rst_n = r;
    model_step(r, e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frames(input int nf);
    for (int i = 0; i < nf * FT; i++) cyc(1'b1);
  endtask

  // monitor: one comparison per presented clock
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      obs_t e, g;
      e = exp_q.pop_front();
      g = '{hs: hsync, vs: vsync, de: de, x: x, y: y, fs: frame_start,
            fc: frame_cnt, rgb: {red, green, blue}};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs#%0d: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b fc=%0d rgb=%h ; want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b fc=%0d rgb=%h",
                 n_cmp, g.hs, g.vs, g.de, g.x, g.y, g.fs, g.fc, g.rgb,
                 e.hs, e.vs, e.de, e.x, e.y, e.fs, e.fc, e.rgb);
      end
    end
  end

  initial begin
    int guard;
    // reset
    for (int i = 0; i < 3; i++) cyc(1'b0);
    // bars, no scroll
    mode = 2'd0; scroll_en = 1'b0; solid_rgb = 16'h1234;
    run_frames(2);
    // mid-frame switch to solid red only takes effect next frame
    for (int i = 0; i < 60; i++) cyc(1'b1);
    mode = 2'd3; solid_rgb = 16'hF800;
    run_frames(2);
    // checker then grid, whole frames
    mode = 2'd1; run_frames(2);
    mode = 2'd2; run_frames(2);
    // scrolling bars over a full offset wrap
    mode = 2'd0; scroll_en = 1'b1;
    run_frames(18);
    scroll_en = 1'b0;
    // reset pulse in the middle of line 2
    while (!(((m_n / HT) % VT) == 2 && (m_n % HT) == 7)) cyc(1'b1);
    cyc(1'b0);
    run_frames(2);
    // random control changes at random moments, including mid-frame
    for (int i = 0; i < 8 * FT; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        solid_rgb = 16'($urandom);
        scroll_en = 1'($urandom_range(0, 1));
      end
      cyc(1'b1);
    end
    // drain
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
